// File: rtl/dsc_epoch_ctrl.sv
// DSC epoch controller: accepts an operand pair, clears and runs the SNG datapath for one epoch,
// and popcounts the returned product bits into a binary result. Optional macro DSC_OVF_CHECK_EN.
module dsc_epoch_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STRIDE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WIDTH-1:0]  i_op_a,
  input  logic [WIDTH-1:0]  i_op_b,
  output logic              o_sng_rst,
  output logic              o_sng_en,
  output logic [WIDTH-1:0]  o_sng_a,
  output logic [WIDTH-1:0]  o_sng_b,
  input  logic [STRIDE-1:0] i_sn_bits,
  input  logic              i_sng_ovf,
  input  logic              i_hold,
  output logic              o_out_valid,
  input  logic              i_out_ready,
`ifdef DSC_OVF_CHECK_EN
  output logic              o_ovf_err,
`endif
  output logic [WIDTH:0]    o_result
);

  localparam int unsigned AW    = WIDTH + 1;
  localparam int unsigned SLOTS = (2 ** WIDTH) / STRIDE;
  localparam logic [WIDTH-1:0] LAST_SLOT = WIDTH'(SLOTS - 1);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_sng_a, r_sng_b, r_slot;
  logic [AW-1:0]    r_acc, r_result, w_pop, w_acc_sum;
  logic             r_out_valid;
  logic             w_load, w_en, w_last;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < STRIDE; i++) begin
      w_pop = w_pop + AW'(i_sn_bits[i]);
    end
  end

  assign w_acc_sum = r_acc + w_pop;

  always_comb begin
    w_state_d  = r_state;
    o_in_ready = 1'b0;
    o_sng_rst  = 1'b0;
    w_en       = 1'b0;
    w_load     = 1'b0;
    w_last     = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_load    = 1'b1;
          w_state_d = StClear;
        end
      end
      StClear: begin
        o_sng_rst = 1'b1;
        w_state_d = StRun;
      end
      StRun: begin
        w_en = ~i_hold;
        if (w_en && (r_slot == LAST_SLOT)) begin
          w_last    = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone: begin
        // Result handshake and next operand accept share the cycle: no IDLE bubble.
        o_in_ready = i_out_ready;
        if (i_out_ready) begin
          if (i_in_valid) begin
            w_load    = 1'b1;
            w_state_d = StClear;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_sng_en = w_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_sng_a     <= '0;
      r_sng_b     <= '0;
      r_slot      <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_out_valid <= (w_state_d == StDone);
      if (w_load) begin
        r_sng_a <= i_op_a;
        r_sng_b <= i_op_b;
      end
      if (r_state == StClear) begin
        r_acc  <= '0;
        r_slot <= '0;
      end else if (w_en) begin
        r_acc  <= w_acc_sum;
        r_slot <= r_slot + WIDTH'(1);
      end
      if (w_last) begin
        r_result <= w_acc_sum;
      end
    end
  end

  assign o_sng_a     = r_sng_a;
  assign o_sng_b     = r_sng_b;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;

`ifdef DSC_OVF_CHECK_EN
  logic r_ovf_err;

  // Overflow must coincide exactly with the last enabled slot of the epoch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf_err <= 1'b0;
    end else if (w_en && (i_sng_ovf != (r_slot == LAST_SLOT))) begin
      r_ovf_err <= 1'b1;
    end
  end

  assign o_ovf_err = r_ovf_err;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = i_sng_ovf;
`endif

endmodule
